// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tmds_pkg
// Description : Shared definitions for the TMDS receive channel. Holds the
//               four control-token codes, symbol and offset widths, and the
//               alignment FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package tmds_pkg;

  localparam int SYM_W = 10;  // one TMDS symbol
  localparam int OFS_W = 4;   // bit-slip offset, 0..9

  // Control tokens, written bit9..bit0 as they appear in the aligned symbol.
  localparam logic [SYM_W-1:0] TMDS_CTRL_00 = 10'h354;
  localparam logic [SYM_W-1:0] TMDS_CTRL_01 = 10'h0AB;
  localparam logic [SYM_W-1:0] TMDS_CTRL_10 = 10'h154;
  localparam logic [SYM_W-1:0] TMDS_CTRL_11 = 10'h2AB;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } tmds_state_e;

endpackage : tmds_pkg
`default_nettype wire

// File: rtl/tmds_channel_decoder_symbol_decode.sv
`default_nettype none
// ============================================================================
// Module      : tmds_symbol_decode
// Description : Decodes one aligned TMDS symbol into video data or a control
//               value. The classification (is_ctrl_o) is combinational so the
//               caller can act on the symbol in the same cycle; data_o,
//               ctrl_o and de_o are registered.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               sym_i        - aligned 10-bit symbol
//               valid_i      - 1 = channel aligned, outputs may carry content
//               data_o       - decoded byte (0 unless a data symbol is valid)
//               ctrl_o       - last control value seen while valid
//               de_o         - 1 = data_o holds a video byte
//               is_ctrl_o    - sym_i is one of the four control tokens
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic [SYM_W-1:0] sym_i,
  input  logic             valid_i,
  output logic [7:0]       data_o,
  output logic [1:0]       ctrl_o,
  output logic             de_o,
  output logic             is_ctrl_o
);

  logic       w_is_ctrl;
  logic [1:0] w_cd;
  logic [7:0] w_unmasked;
  logic [7:0] w_data;

  logic [7:0] data_q;
  logic [1:0] ctrl_q;
  logic       de_q;

  always_comb begin
    w_is_ctrl = 1'b1;
    w_cd      = 2'b00;
    case (sym_i)
      TMDS_CTRL_00: w_cd = 2'b00;
      TMDS_CTRL_01: w_cd = 2'b01;
      TMDS_CTRL_10: w_cd = 2'b10;
      TMDS_CTRL_11: w_cd = 2'b11;
      default:      w_is_ctrl = 1'b0;
    endcase

    // bit9 marks an inverted payload, bit8 selects XOR vs XNOR chaining
    w_unmasked = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
    w_data     = 8'h00;
    w_data[0]  = w_unmasked[0];
    for (int i = 1; i < 8; i++) begin
      w_data[i] = sym_i[8] ? (w_unmasked[i] ^ w_unmasked[i-1])
                           : ~(w_unmasked[i] ^ w_unmasked[i-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= 8'h00;
      ctrl_q <= 2'b00;
      de_q   <= 1'b0;
    end else if (valid_i && w_is_ctrl) begin
      data_q <= 8'h00;
      ctrl_q <= w_cd;
      de_q   <= 1'b0;
    end else if (valid_i) begin
      data_q <= w_data;
      de_q   <= 1'b1;
    end else begin
      // not aligned: suppress content, keep the last control value
      data_q <= 8'h00;
      de_q   <= 1'b0;
    end
  end

  assign data_o    = data_q;
  assign ctrl_o    = ctrl_q;
  assign de_o      = de_q;
  assign is_ctrl_o = w_is_ctrl;

endmodule : tmds_symbol_decode
`default_nettype wire

// File: rtl/tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tmds_channel_decoder
// Description : One TMDS receive channel. Finds the symbol boundary in the
//               deserialised 10-bit stream by bit-slipping until a run of
//               control tokens appears, then decodes video data / control.
// Ports       : clk     - pixel clock
//               reset   - synchronous active-high reset
//               raw     - deserialised word, raw[0] received first
//               data    - decoded video byte
//               ctrl    - last decoded control value {C1,C0}
//               de      - 1 = data is a video byte this cycle
//               locked  - symbol alignment achieved
//               offset  - current bit-slip offset, 0..9
// Revision    : 1.0 - initial release
// ============================================================================
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int CTRL_RUN      = 8,
  parameter int SEARCH_WINDOW = 2048,
  parameter int LOSS_WINDOW   = 4096
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [SYM_W-1:0] raw,
  output logic [7:0]       data,
  output logic [1:0]       ctrl,
  output logic             de,
  output logic             locked,
  output logic [OFS_W-1:0] offset
);

  localparam int STW  = $clog2(SEARCH_WINDOW);
  localparam int LTW  = $clog2(LOSS_WINDOW);
  localparam int RUNW = $clog2(CTRL_RUN + 1);

  localparam logic [STW-1:0]  c_STIMER_LAST = STW'(SEARCH_WINDOW - 1);
  localparam logic [LTW-1:0]  c_LTIMER_LAST = LTW'(LOSS_WINDOW - 1);
  localparam logic [RUNW-1:0] c_RUN_FULL    = RUNW'(CTRL_RUN);
  localparam logic [RUNW-1:0] c_RUN_LAST    = RUNW'(CTRL_RUN - 1);
  // symbols already in the pipeline when the offset moves are not trusted
  localparam logic [1:0]      c_SKIP_CYCLES = 2'd2;

  logic [SYM_W-1:0]   prev_raw_q;
  logic [2*SYM_W-1:0] w_cat;
  logic [SYM_W-1:0]   w_win [SYM_W];
  logic [SYM_W-1:0]   sym_q;
  logic               w_is_ctrl;
  logic               w_unused_msb;
  logic [OFS_W-1:0]   w_next_offset;

  tmds_state_e        state_q,  state_d;
  logic [OFS_W-1:0]   offset_q, offset_d;
  logic [RUNW-1:0]    run_q,    run_d;
  logic [STW-1:0]     stimer_q, stimer_d;
  logic [LTW-1:0]     ltimer_q, ltimer_d;
  logic [1:0]         skip_q,   skip_d;

  assign w_cat        = {raw, prev_raw_q};
  // no window starts high enough to reach the top bit
  assign w_unused_msb = w_cat[2*SYM_W-1];

  for (genvar k = 0; k < SYM_W; k++) begin : g_win
    assign w_win[k] = w_cat[k +: SYM_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_raw_q <= '0;
      sym_q      <= '0;
    end else begin
      prev_raw_q <= raw;
      sym_q      <= w_win[offset_q];
    end
  end

  tmds_symbol_decode u_decode (
    .clk       (clk),
    .reset     (reset),
    .sym_i     (sym_q),
    .valid_i   (state_q == LOCKED),
    .data_o    (data),
    .ctrl_o    (ctrl),
    .de_o      (de),
    .is_ctrl_o (w_is_ctrl)
  );

  assign w_next_offset = (offset_q == OFS_W'(9)) ? '0 : offset_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    run_d    = run_q;
    stimer_d = stimer_q;
    ltimer_d = ltimer_q;
    skip_d   = skip_q;

    case (state_q)
      SEARCH: begin
        if (skip_q != 2'd0) begin
          skip_d = skip_q - 2'd1;
          run_d  = '0;
        end else if (w_is_ctrl) begin
          run_d = (run_q == c_RUN_FULL) ? run_q : run_q + 1'b1;
        end else begin
          run_d = '0;
        end

        // lock takes priority over a slip due on the same cycle
        if (skip_q == 2'd0 && w_is_ctrl && run_q == c_RUN_LAST) begin
          state_d  = LOCKED;
          run_d    = '0;
          stimer_d = '0;
          ltimer_d = '0;
        end else if (stimer_q == c_STIMER_LAST) begin
          offset_d = w_next_offset;
          run_d    = '0;
          stimer_d = '0;
          skip_d   = c_SKIP_CYCLES;
        end else begin
          stimer_d = stimer_q + 1'b1;
        end
      end

      LOCKED: begin
        if (w_is_ctrl) begin
          ltimer_d = '0;
        end else if (ltimer_q == c_LTIMER_LAST) begin
          state_d  = SEARCH;
          offset_d = w_next_offset;
          run_d    = '0;
          stimer_d = '0;
          ltimer_d = '0;
          skip_d   = c_SKIP_CYCLES;
        end else begin
          ltimer_d = ltimer_q + 1'b1;
        end
      end

      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= SEARCH;
      offset_q <= '0;
      run_q    <= '0;
      stimer_q <= '0;
      ltimer_q <= '0;
      skip_q   <= '0;
    end else begin
      state_q  <= state_d;
      offset_q <= offset_d;
      run_q    <= run_d;
      stimer_q <= stimer_d;
      ltimer_q <= ltimer_d;
      skip_q   <= skip_d;
    end
  end

  assign locked = (state_q == LOCKED);
  assign offset = offset_q;

endmodule : tmds_channel_decoder
`default_nettype wire

// File: tb/tb_tmds_channel_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_tmds_channel_decoder
// Description : Self-checking bench for tmds_channel_decoder. Output words
//               are predicted when the raw word is driven and compared three
//               cycles later; lock/offset behaviour is checked directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tmds_channel_decoder;
  import tmds_pkg::*;

  localparam int CTRL_RUN = 8;
  localparam int SW       = 2048;
  localparam int LW       = 4096;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] raw;
  logic [7:0] data;
  logic [1:0] ctrl;
  logic       de;
  logic       locked;
  logic [3:0] offset;

  always #5 clk = ~clk;

  tmds_channel_decoder #(
    .CTRL_RUN      (CTRL_RUN),
    .SEARCH_WINDOW (SW),
    .LOSS_WINDOW   (LW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .raw    (raw),
    .data   (data),
    .ctrl   (ctrl),
    .de     (de),
    .locked (locked),
    .offset (offset)
  );

  typedef struct {
    bit         chk;
    logic [7:0] data;
    logic [1:0] ctrl;
    logic       de;
  } exp_t;

  exp_t  sb[$];
  int    errors = 0;
  int    checks = 0;
  string phase  = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s observed=0x%0h expected=0x%0h", phase, tag, obs, exp);
    end
  endtask

  // Drive one raw word for one cycle; its expected output leaves the
  // scoreboard three cycles (two further steps) later.
  task automatic step(input logic [9:0] w, input bit chk, input logic [7:0] ed,
                      input logic [1:0] ec, input logic ede);
    exp_t e;
    exp_t got;
    raw = w;
    @(posedge clk);
    #1;
    e.chk  = chk;
    e.data = ed;
    e.ctrl = ec;
    e.de   = ede;
    sb.push_back(e);
    if (sb.size() == 3) begin
      got = sb.pop_front();
      if (got.chk)
        check("out{data,ctrl,de}", {21'd0, data, ctrl, de}, {21'd0, got.data, got.ctrl, got.de});
    end
  endtask

  task automatic do_reset(input int n);
    sb.delete();
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      raw = 10'($urandom);
      @(posedge clk);
      #1;
      check("reset_outs", {16'd0, data, ctrl, de, locked, offset}, 32'd0);
    end
    reset = 1'b0;
  endtask

  // Stream whose true boundary sits at bit 3; lock expected at offset 3.
  task automatic slip_search(input string tag);
    logic [9:0] tok;
    logic [9:0] w;
    logic [3:0] last;
    int         chg [4];
    int         n;
    tok  = TMDS_CTRL_00;
    w    = {tok[6:0], tok[9:7]};
    chg  = '{-1, -1, -1, -1};
    last = offset;
    n    = 0;
    while (!locked && n < 3 * SW + CTRL_RUN + 3) begin
      step(w, 1'b1, 8'h00, 2'b00, 1'b0);
      n++;
      if (offset != last) begin
        if (offset < 4) chg[offset] = n;
        last = offset;
      end
    end
    check({tag, "_locked"}, 32'(locked), 32'd1);
    check({tag, "_offset"}, 32'(offset), 32'd3);
    check({tag, "_to_ofs1"}, chg[1], SW);
    check({tag, "_to_ofs2"}, chg[2], 2 * SW);
    check({tag, "_to_ofs3"}, chg[3], 3 * SW);
  endtask

  initial begin
    int n;
    logic [9:0] tok_rot;
    logic [9:0] tok;
    reset = 1'b1;
    raw   = '0;

    phase = "reset";
    do_reset(3);

    phase = "align";
    step(TMDS_CTRL_00, 1'b1, 8'h00, 2'b00, 1'b0);
    check("release_outs", {16'd0, data, ctrl, de, locked, offset}, 32'd0);
    n = 1;
    while (!locked && n < CTRL_RUN + 3) begin
      step(TMDS_CTRL_00, 1'b1, 8'h00, 2'b00, 1'b0);
      n++;
    end
    check("locked", 32'(locked), 32'd1);
    check("offset", 32'(offset), 32'd0);
    repeat (4) step(TMDS_CTRL_00, 1'b1, 8'h00, 2'b00, 1'b0);
    check("ctrl_de", {29'd0, ctrl, de}, 32'd0);

    phase = "decode";
    step(10'h100, 1'b1, 8'h00, 2'b00, 1'b1);
    step(10'h2FF, 1'b1, 8'hFE, 2'b00, 1'b1);
    step(10'h2AB, 1'b1, 8'h00, 2'b11, 1'b0);
    step(10'h100, 1'b1, 8'h00, 2'b11, 1'b1);
    repeat (4) step(TMDS_CTRL_00, 1'b1, 8'h00, 2'b00, 1'b0);
    check("still_locked", 32'(locked), 32'd1);

    phase = "loss";
    for (int j = 0; j < LW + 2; j++) begin
      step(10'h100, (j != LW - 1), 8'h00, 2'b00, (j < LW - 1));
      if (j == LW) check("locked_before_drop", 32'(locked), 32'd1);
      if (j == LW + 1) begin
        check("locked_after_drop", 32'(locked), 32'd0);
        check("offset_after_drop", 32'(offset), 32'd1);
      end
    end
    repeat (6) step(10'h100, 1'b1, 8'h00, 2'b00, 1'b0);
    check("stays_unlocked", 32'(locked), 32'd0);

    phase = "slip";
    do_reset(2);
    slip_search("slip");

    phase = "midreset";
    tok     = TMDS_CTRL_00;
    tok_rot = {tok[6:0], tok[9:7]};
    repeat (3) step(tok_rot, 1'b1, 8'h00, 2'b00, 1'b0);
    check("locked_before_reset", 32'(locked), 32'd1);
    sb.delete();
    reset = 1'b1;
    raw   = tok_rot;
    @(posedge clk);
    #1;
    check("after_reset", {29'd0, locked, de, offset != 4'd0}, 32'd0);
    check("offset_after_reset", 32'(offset), 32'd0);
    reset = 1'b0;
    slip_search("relock");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_tmds_channel_decoder
`default_nettype wire

// File: doc/tmds_channel_decoder.md
Name: tmds_channel_decoder

Overview:
- Receive-side counterpart of the TMDS encode/serialise path: recovers one TMDS channel from 10-bit parallel words delivered by a 10:1 deserialiser running on the pixel clock.
- The deserialiser's word boundary is arbitrary. The block finds symbol alignment by bit-slipping until control tokens appear in runs.
- It then decodes each symbol into 8-bit video data, 2-bit control (HSync/VSync on the blue channel) and data-enable.
- Three instances, one per colour channel, form the core of the HDMI input path.

Parameters:
- CTRL_RUN, 8: consecutive control tokens at the current offset required to declare lock.
- SEARCH_WINDOW, 2048: cycles spent at one offset without reaching CTRL_RUN before slipping to the next offset.
- LOSS_WINDOW, 4096: cycles without any control token while locked before lock is dropped.

Ports:
- clk  in  1  pixel clock; all logic on posedge.
- reset  in  1  synchronous reset, active-high.
- raw  in  10  deserialised word; raw[0] is the earliest-received bit.
- data  out  8  decoded video byte.
- ctrl  out  2  last decoded control value {C1,C0}.
- de  out  1  1 = data is a valid video byte this cycle.
- locked  out  1  alignment achieved.
- offset  out  4  current bit-slip offset, 0..9.

Behaviour:
- Reset:
  - data=0, ctrl=0, de=0, locked=0, offset=0.
  - prev-word register=0, run counter=0, timers=0, state=SEARCH.
  - Reset mid-lock clears all of these on the next edge.
- Windowing:
  - Concatenate cat = {raw, prev_raw} (20 bits); prev_raw is raw delayed one cycle.
  - Aligned symbol sym = cat[offset +: 10].
  - sym is registered: stage 1.
- Control tokens (bit9..bit0):
  - 0x354 -> CD=00, 0x0AB -> CD=01, 0x154 -> CD=10, 0x2AB -> CD=11.
  - Any other value is a data symbol.
- Data decode (stage 2, registered):
  - q = sym[9] ? ~sym[7:0] : sym[7:0].
  - d[0] = q[0].
  - for i=1..7: d[i] = sym[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]).
- Latency: raw to data/ctrl/de is 3 cycles (prev register, stage 1, stage 2). locked and offset are not pipelined.
- Output rules:
  - data symbol while locked: de=1, data=d, ctrl holds.
  - control token while locked: de=0, ctrl=CD, data=0.
  - not locked: de=0, data=0, ctrl holds its last value (0 after reset).
- FSM, evaluated on the stage-1 symbol:
  - SEARCH:
    - Control token: run++; otherwise run=0.
    - run reaches CTRL_RUN: go to LOCKED, locked=1 on that edge, loss timer=0.
    - Otherwise, when the search timer reaches SEARCH_WINDOW-1: offset = (offset==9) ? 0 : offset+1; run=0; timer=0.
    - The first 2 cycles after an offset change are discarded, since the pipeline still holds the old offset; run stays 0.
  - LOCKED:
    - Control token: loss timer=0; otherwise loss timer++.
    - Loss timer reaches LOSS_WINDOW-1: go to SEARCH, locked=0, offset advances by 1 mod 10, all counters cleared.
  - Simultaneous run completion and search-timer expiry: lock wins; offset is not slipped.
- Widths:
  - Timers are $clog2 of their window, saturating-safe.
  - run saturates at CTRL_RUN.
  - offset wrap 9 -> 0.

Decomposition:
- Package tmds_pkg:
  - control-token constants TMDS_CTRL_00/01/10/11.
  - FSM state enum {SEARCH, LOCKED}.
  - symbol width 10, offset width 4.
- One natural sub-module: tmds_symbol_decode.
  - Registered; sym in -> data/ctrl/is_ctrl out.
  - Reusable by any future audio/data-island decoder.

Test Plan:
- Reset: assert reset 3 cycles with random raw -> data=0, ctrl=0, de=0, locked=0, offset=0 throughout and on the first cycle after release.
- Aligned lock: continuous 0x354 at offset 0 -> locked=1 within CTRL_RUN+3 cycles; offset=0; ctrl=00; de=0.
- Slip search: continuous 0x354 stream pre-rotated so the boundary is at bit 3 -> offsets 0,1,2 each held exactly SEARCH_WINDOW cycles, no false lock; locked=1 with offset=3 within 3*SEARCH_WINDOW+CTRL_RUN+3 cycles.
- Decode: once locked, feed 0x100, 0x2FF, 0x2AB, 0x100 -> 3 cycles later:
  - data=0x00, de=1
  - then data=0xFE, de=1
  - then de=0, ctrl=11
  - then data=0x00, de=1, ctrl still 11
- Loss: locked, feed LOSS_WINDOW data words (0x100) with no control token -> locked falls exactly at the LOSS_WINDOW-th stage-1 data symbol; offset goes 0 -> 1; de=0 afterwards.
- Reset mid-lock: locked at offset 3, assert reset 1 cycle -> next edge locked=0, offset=0, de=0; relock follows the slip-search timing.
